// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types for the two-requester memory arbiter
// Holds the FSM state enum, the owner enum, grant bit positions and the
// timeout counter width helper. Optional feature macro: MEM_ARB_RR_EN.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // bit positions inside the one-hot grant vector
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

    // the timeout counter is a byte for every TIMEOUT that fits in one
    function automatic int cnt_width(input int timeout);
        return (timeout <= 255) ? 8 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// rtl/mem_arb_grant.sv - grant selection between fetch and load/store requesters
// Ports: ifu_valid, lsu_valid (requests), last_served (owner of the previous
// grant), grant (one-hot, bit GNT_IFU / GNT_LSU, all-zero when nobody asks).
// MEM_ARB_RR_EN defined: simultaneous requests go to whoever was not served
// last. Undefined: LSU always beats IFU and last_served is ignored.
module mem_arb_grant
    import mem_arbiter_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_t     last_served,
    output logic [1:0] grant
);

`ifndef MEM_ARB_RR_EN
    logic unused_last_served;
    assign unused_last_served = (last_served == OWN_LSU);
`endif

    always_comb begin
        grant = 2'b00;
        if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            if (last_served == OWN_LSU) grant[GNT_IFU] = 1'b1;
            else                        grant[GNT_LSU] = 1'b1;
`else
            grant[GNT_LSU] = 1'b1;
`endif
        end else if (lsu_valid) begin
            grant[GNT_LSU] = 1'b1;
        end else if (ifu_valid) begin
            grant[GNT_IFU] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-outstanding memory arbiter for fetch and load/store
// Ports: clk, rst (async active-low); ifu_* fetch request/response; lsu_*
// load/store request/response; mem_* downstream request/response; busy.
// Responses are combinational from the WAIT state so the shortest path from
// accept to response is two cycles. A WAIT that sees no response for TIMEOUT
// cycles answers the owner with err=1 on the following cycle.
// Optional feature macro: MEM_ARB_RR_EN (round-robin grant).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic                ifu_resp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_wen,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int              CNT_W     = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                state, state_nxt;
    owner_t                owner, last_served;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic                  wen_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wmask_q;
    logic [1:0]            grant;
    logic                  accept, timed_out, resp_fire;
    logic [DATA_W-1:0]     resp_data;

    mem_arb_grant u_grant (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_served (last_served),
        .grant       (grant)
    );

    assign accept    = (state == ST_IDLE) && (grant != 2'b00);
    assign timed_out = (state == ST_WAIT) && (cnt == CNT_LIMIT);

`ifdef MEM_ARB_RR_EN
    // reset to LSU so that IFU wins the first contested grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        last_served <= OWN_LSU;
        else if (accept) last_served <= grant[GNT_LSU] ? OWN_LSU : OWN_IFU;
    end
`else
    assign last_served = OWN_LSU;
`endif

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)                       state_nxt = ST_REQ;
            ST_REQ:  if (mem_req_ready)                state_nxt = ST_WAIT;
            ST_WAIT: if (mem_resp_valid || timed_out)  state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    // latched request, owner and wait counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner   <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt     <= '0;
        end else begin
            if (accept) begin
                if (grant[GNT_LSU]) begin
                    owner   <= OWN_LSU;
                    addr_q  <= lsu_addr;
                    wen_q   <= lsu_wen;
                    wdata_q <= lsu_wdata;
                    wmask_q <= lsu_wmask;
                end else begin
                    owner   <= OWN_IFU;
                    addr_q  <= ifu_addr;
                    wen_q   <= 1'b0;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end
            end
            if (state == ST_REQ && mem_req_ready)
                cnt <= '0;
            else if (state == ST_WAIT && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;
        end
    end

    // outputs; readies are gated by rst so nothing is accepted while held in reset
    always_comb begin
        mem_req_valid  = (state == ST_REQ);
        busy           = (state != ST_IDLE);
        ifu_req_ready  = rst && (state == ST_IDLE) && grant[GNT_IFU];
        lsu_req_ready  = rst && (state == ST_IDLE) && grant[GNT_LSU];
        resp_fire      = (state == ST_WAIT) && (mem_resp_valid || timed_out);
        resp_data      = ((state == ST_WAIT) && mem_resp_valid) ? mem_rdata : '0;
        ifu_resp_valid = resp_fire && (owner == OWN_IFU);
        lsu_resp_valid = resp_fire && (owner == OWN_LSU);
        ifu_resp_err   = timed_out && !mem_resp_valid && (owner == OWN_IFU);
        lsu_resp_err   = timed_out && !mem_resp_valid && (owner == OWN_LSU);
        ifu_rdata      = (owner == OWN_IFU) ? resp_data : '0;
        lsu_rdata      = (owner == OWN_LSU) ? resp_data : '0;
    end

    assign mem_addr  = addr_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = wdata_q;
    assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 4;
    localparam int MW      = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [MW-1:0]     lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [MW-1:0]     mem_wmask;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .busy(busy)
    );

    int total = 0;
    int fails = 0;
    bit model_last_lsu = 1'b1;   // reference: who was served last (RR build only)
    bit w;
    bit ip, lp, iv, lv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, {ifu_req_ready, lsu_req_ready}, 0);
        chk({tag, "_resp"}, {ifu_resp_valid, lsu_resp_valid, ifu_resp_err, lsu_resp_err}, 0);
        chk({tag, "_rdata"}, {ifu_rdata, lsu_rdata}, 0);
        chk({tag, "_mem"}, {mem_req_valid, mem_wen, busy, mem_wmask}, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // One complete transaction. The memory side holds mem_req_ready low for
    // rdly cycles, then answers d cycles after the request handshake.
    task automatic run_txn(input bit iv_i, input bit lv_i, input int rdly, input int d,
                           input logic [DATA_W-1:0] rdata, input bit junk, output bit win_lsu);
        logic [ADDR_W-1:0] e_addr;
        logic              e_wen;
        logic [DATA_W-1:0] e_wdata, e_data;
        logic [MW-1:0]     e_mask;
        bit                done, e_v, e_err;

        if (iv_i && lv_i) begin
`ifdef MEM_ARB_RR_EN
            win_lsu = !model_last_lsu;
`else
            win_lsu = 1'b1;
`endif
        end else begin
            win_lsu = lv_i;
        end
        model_last_lsu = win_lsu;
        e_addr  = win_lsu ? lsu_addr : ifu_addr;
        e_wen   = win_lsu ? lsu_wen : 1'b0;
        e_wdata = lsu_wdata;
        e_mask  = lsu_wmask;

        // IDLE: accept, a stray response strobe here must be ignored
        tick();
        ifu_req_valid  = iv_i;
        lsu_req_valid  = lv_i;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_rdata      = $urandom;
        #1;
        chk("idle_busy", busy, 0);
        chk("ifu_ready", ifu_req_ready, iv_i && !win_lsu);
        chk("lsu_ready", lsu_req_ready, lv_i && win_lsu);
        chk("idle_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("idle_mem_valid", mem_req_valid, 0);

        // REQ: fields held while the winner's inputs change under it
        for (int r = 0; r <= rdly; r++) begin
            tick();
            if (win_lsu) begin
                lsu_req_valid = 1'b0;
                lsu_addr  = $urandom;
                lsu_wdata = $urandom;
                lsu_wen   = 1'($urandom);
                lsu_wmask = MW'($urandom);
            end else begin
                ifu_req_valid = 1'b0;
                ifu_addr = $urandom;
            end
            mem_req_ready  = (r == rdly);
            mem_resp_valid = (r != rdly) && junk;
            mem_rdata      = $urandom;
            #1;
            chk("req_valid", mem_req_valid, 1);
            chk("req_busy", busy, 1);
            chk("req_addr", mem_addr, e_addr);
            chk("req_wen", mem_wen, e_wen);
            if (win_lsu) begin
                chk("req_wdata", mem_wdata, e_wdata);
                chk("req_wmask", mem_wmask, e_mask);
            end
            chk("req_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("req_no_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        end

        // WAIT: response d-1 cycles in, or error after TIMEOUT silent cycles
        done = 1'b0;
        for (int k = 0; k <= TIMEOUT && !done; k++) begin
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = (k == d - 1);
            mem_rdata      = (k == d - 1) ? rdata : DATA_W'($urandom);
            #1;
            e_v = 1'b0; e_err = 1'b0; e_data = '0;
            if (k == d - 1) begin
                e_v = 1'b1; e_data = rdata; done = 1'b1;
            end else if (k == TIMEOUT) begin
                e_v = 1'b1; e_err = 1'b1; done = 1'b1;
            end
            chk("wait_busy", busy, 1);
            chk("wait_mem_valid", mem_req_valid, 0);
            chk("wait_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("ifu_resp_valid", ifu_resp_valid, !win_lsu && e_v);
            chk("ifu_resp_err", ifu_resp_err, !win_lsu && e_err);
            chk("ifu_rdata", ifu_rdata, !win_lsu ? e_data : '0);
            chk("lsu_resp_valid", lsu_resp_valid, win_lsu && e_v);
            chk("lsu_resp_err", lsu_resp_err, win_lsu && e_err);
            chk("lsu_rdata", lsu_rdata, win_lsu ? e_data : '0);
        end
        chk("txn_done", done, 1);
    endtask

    initial begin
        rst = 1'b0;
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;

        // reset: requests and a response strobe present, everything stays quiet
        tick();
        tick();
        ifu_req_valid = 1; lsu_req_valid = 1; mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
        #1;
        chk_all_zero("reset");
        ifu_req_valid = 0; lsu_req_valid = 0; mem_resp_valid = 0;
        rst = 1'b1;

        // fetch with fastest memory
        ifu_addr = 32'h8000_0000;
        run_txn(1, 0, 0, 1, 32'h0000_0413, 0, w);

        // store with 3 cycles of backpressure, stray strobes during REQ
        lsu_addr = 32'h8000_1000; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        run_txn(0, 1, 3, 2, 32'h0, 1, w);

        // contested grants, winner re-requests each time
        ifu_addr = 32'h0000_1000; lsu_addr = 32'h0000_2000; lsu_wen = 0;
        run_txn(1, 1, 0, 1, 32'hA5A5_0001, 0, w);
        run_txn(1, 1, 1, 2, 32'hA5A5_0002, 0, w);
        run_txn(1, 1, 0, 3, 32'hA5A5_0003, 0, w);
        run_txn(!w, w, 0, 1, 32'hA5A5_0004, 0, w);

        // timeouts and the boundary where the response lands on the last cycle
        ifu_addr = 32'h0000_3000;
        run_txn(1, 0, 0, TIMEOUT + 3, 32'hFFFF_FFFF, 0, w);
        lsu_addr = 32'h0000_4000; lsu_wen = 1;
        run_txn(0, 1, 2, TIMEOUT + 2, 32'hFFFF_FFFF, 0, w);
        run_txn(1, 0, 0, TIMEOUT + 1, 32'hCAFE_F00D, 0, w);

        // reset while waiting drops the transaction
        tick();
        ifu_req_valid = 1; ifu_addr = 32'h0000_5000; mem_resp_valid = 0;
        tick();
        ifu_req_valid = 0; mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        #1;
        chk("pre_reset_busy", busy, 1);
        rst = 1'b0;
        ifu_req_valid = 1;
        #1;
        chk_all_zero("wait_reset");
        tick();
        rst = 1'b1; ifu_req_valid = 0; mem_resp_valid = 1; mem_rdata = 32'h0BAD_0BAD;
        #1;
        chk("late_resp", {ifu_resp_valid, lsu_resp_valid, busy}, 0);
        tick();
        #1;
        chk("late_resp2", {ifu_resp_valid, lsu_resp_valid, busy}, 0);
        model_last_lsu = 1'b1;

        // randomized traffic; the loser of a contest keeps its request up
        ip = 0; lp = 0;
        for (int i = 0; i < 24; i++) begin
            iv = ip | 1'($urandom_range(0, 1));
            lv = lp | 1'($urandom_range(0, 1));
            if (!iv && !lv) lv = 1'b1;
            if (!ip) ifu_addr = $urandom;
            if (!lp) begin
                lsu_addr = $urandom; lsu_wdata = $urandom;
                lsu_wen = 1'($urandom); lsu_wmask = MW'($urandom);
            end
            run_txn(iv, lv, $urandom_range(0, 3), $urandom_range(1, TIMEOUT + 2),
                    DATA_W'($urandom), 1'($urandom_range(0, 1)), w);
            ip = iv && w;
            lp = lv && !w;
        end

        tick();
        mem_resp_valid = 0; ifu_req_valid = 0; lsu_req_valid = 0;
        tick();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
